// File: rtl/divider_const_pkg.sv
// Shared constants for the divide-by-constant blocks.
//
// Every constant divider derives its reciprocal through ceil_recip() so the
// rounding is identical across the codebase. The DEF_* names are defaults
// only; each block exposes them as overridable parameters.
package divider_const_pkg;

    localparam int DEF_BWI1    = 10;  // dividend width
    localparam int DEF_BWI2    = 14;  // reciprocal width / product right-shift
    localparam int DEF_BWO1    = 10;  // quotient width
    localparam int DEF_BWR     = 4;   // remainder width, 2^BWR > divisor
    localparam int DEF_DIVISOR = 11;

    // ceil(2^bw / d): rounding up keeps the estimate from falling short for
    // small dividends, and any overshoot is bounded by the dividend width.
    function automatic int ceil_recip(input int bw, input int d);
        return ((1 << bw) + d - 1) / d;
    endfunction

    localparam int DEF_CONST_MULTI = ceil_recip(DEF_BWI2, DEF_DIVISOR);

endpackage

// File: rtl/divmod_correct.sv
// Combinational +/-1 correction for a reciprocal-estimated quotient.
//
// Ports:
//   q_est  in   BWO1  quotient estimate
//   r_raw  in   RW    signed remainder x - q_est*DIVISOR
//   q      out  BWO1  corrected quotient
//   r      out  BWR   corrected remainder
//   bad    out  1     corrected remainder still outside [0, DIVISOR-1],
//                     i.e. the estimate was off by more than one
module divmod_correct #(
    parameter int BWO1    = 10,
    parameter int BWR     = 4,
    parameter int RW      = 12,
    parameter int DIVISOR = 11
) (
    input  logic [BWO1-1:0]       q_est,
    input  logic signed [RW-1:0]  r_raw,
    output logic [BWO1-1:0]       q,
    output logic [BWR-1:0]        r,
    output logic                  bad
);

    localparam logic signed [RW-1:0] DIV_S = RW'(DIVISOR);
    localparam logic [BWO1-1:0]      ONE   = BWO1'(1);

    logic signed [RW-1:0] r_c;

    always_comb begin
        q   = q_est;
        r_c = r_raw;
        if (r_raw[RW-1]) begin
            // estimate one too high
            q   = q_est - ONE;
            r_c = r_raw + DIV_S;
        end else if (r_raw >= DIV_S) begin
            // estimate one too low
            q   = q_est + ONE;
            r_c = r_raw - DIV_S;
        end
    end

    assign bad = r_c[RW-1] || (r_c >= DIV_S);
    assign r   = BWR'(r_c);

endmodule

// File: rtl/divmod_const_11_pipe.sv
// Pipelined unsigned divide-by-11 with remainder, valid/ready on both sides.
//
//   stage 1: capture dividend
//   stage 2: q_est = (x * CONST_MULTI) >> BWI2
//   stage 3: r_raw = x - q_est*DIVISOR (signed, BWI1+2 bits)
//   stage 4: +/-1 correction, drives outputs; err is sticky
//
// The whole pipe freezes while the output is held (out_valid && !out_ready);
// otherwise every stage advances, bubbles included. in_ready is the
// combinational inverse of that stall, so an input can be taken in the same
// cycle the output drains.
//
// Ports:
//   clk, rst   clock (rising), asynchronous active-high reset
//   in_valid   dividend valid          in_ready  block can accept
//   i1         unsigned dividend
//   out_valid  result valid            out_ready downstream accepts
//   o1         quotient                o2        remainder
//   err        sticky: estimate was off by more than one
module divmod_const_11_pipe
    import divider_const_pkg::*;
#(
    parameter int BWI1        = DEF_BWI1,
    parameter int BWI2        = DEF_BWI2,
    parameter int BWO1        = DEF_BWO1,
    parameter int BWR         = DEF_BWR,
    parameter int DIVISOR     = DEF_DIVISOR,
    parameter int CONST_MULTI = ceil_recip(BWI2, DIVISOR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BWI1-1:0] i1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BWO1-1:0] o1,
    output logic [BWR-1:0]  o2,
    output logic            err
);

    localparam int STAGES = 4;
    localparam int PW     = BWI1 + BWI2;  // full product, never truncated
    localparam int RW     = BWI1 + 2;     // signed remainder width

    logic              stall;
    logic              accept;
    logic [STAGES:1]   vld_pipe;

    logic [BWI1-1:0]       x1, x2;
    logic [BWO1-1:0]       q2, q3;
    logic signed [RW-1:0]  r3;

    logic [PW-1:0]         prod;
    logic [BWO1-1:0]       q_est_c;
    logic [RW-1:0]         p_c;
    logic signed [RW-1:0]  r_raw_c;

    logic [BWO1-1:0]       q_fix;
    logic [BWR-1:0]        r_fix;
    logic                  bad;

    assign out_valid = vld_pipe[STAGES];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;

    // stage 2 datapath
    assign prod    = PW'(x1) * PW'(CONST_MULTI);
    assign q_est_c = BWO1'(prod >> BWI2);

    // stage 3 datapath
    assign p_c     = RW'(q2) * RW'(DIVISOR);
    assign r_raw_c = $signed({2'b00, x2}) - $signed(p_c);

    // stage 4 datapath
    divmod_correct #(
        .BWO1    (BWO1),
        .BWR     (BWR),
        .RW      (RW),
        .DIVISOR (DIVISOR)
    ) u_correct (
        .q_est (q3),
        .r_raw (r3),
        .q     (q_fix),
        .r     (r_fix),
        .bad   (bad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            x1       <= '0;
            x2       <= '0;
            q2       <= '0;
            q3       <= '0;
            r3       <= '0;
            o1       <= '0;
            o2       <= '0;
            err      <= 1'b0;
        end else if (!stall) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            // data of bubbles is don't-care, so only the valid bits gate
            x1       <= i1;
            x2       <= x1;
            q2       <= q_est_c;
            q3       <= q2;
            r3       <= r_raw_c;
            if (vld_pipe[STAGES-1]) begin
                o1 <= q_fix;
                o2 <= r_fix;
                if (bad)
                    err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_divmod_const_11_pipe.sv
module tb_divmod_const_11_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [9:0] i1;

    // default-constant DUT
    logic       in_ready, out_valid, err;
    logic [9:0] o1;
    logic [3:0] o2;
    // CONST_MULTI=1489: estimate can be one low, corrected
    logic       rdy89, vld89, err89;
    logic [9:0] q89;
    logic [3:0] r89;
    // CONST_MULTI=1400: estimate far off, err must set and stick
    logic       rdy00, vld00, err00;
    logic [9:0] q00;
    logic [3:0] r00;

    divmod_const_11_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .i1(i1),
        .out_valid(out_valid), .out_ready(out_ready), .o1(o1), .o2(o2), .err(err)
    );

    divmod_const_11_pipe #(.CONST_MULTI(1489)) u_c89 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy89), .i1(i1),
        .out_valid(vld89), .out_ready(out_ready), .o1(q89), .o2(r89), .err(err89)
    );

    divmod_const_11_pipe #(.CONST_MULTI(1400)) u_c00 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy00), .i1(i1),
        .out_valid(vld00), .out_ready(out_ready), .o1(q00), .o2(r00), .err(err00)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [9:0] din;
        logic [9:0] q;
        logic [3:0] r;
        logic       e00;  // expected sticky err of the CONST_MULTI=1400 DUT
    } vec_t;

    vec_t vecs[5];

    // scoreboard for streamed phases
    bit         sb_en = 1'b0;
    int         sb_q[$];
    int         rx_cnt = 0;
    int         stall_cnt = 0;
    bit         prev_stall = 1'b0;
    logic [9:0] prev_o1;
    logic [3:0] prev_o2;

    always @(negedge clk) begin
        if (sb_en) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got result %0d/%0d, want none", o1, o2);
                end else begin
                    int d;
                    d = sb_q.pop_front();
                    chk($sformatf("stream_q[%0d]", d), 32'(o1), 32'(d / 11));
                    chk($sformatf("stream_r[%0d]", d), 32'(o2), 32'(d % 11));
                end
                rx_cnt++;
            end
            if (out_valid && !out_ready) begin
                stall_cnt++;
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                if (prev_stall) begin
                    chk("hold_o1", 32'(o1), 32'(prev_o1));
                    chk("hold_o2", 32'(o2), 32'(prev_o2));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_o1    = o1;
            prev_o2    = o2;
            if (in_valid && in_ready)
                sb_q.push_back(int'(i1));
        end
    end

    int bp_vals[5] = '{37, 255, 512, 700, 999};

    initial begin
        int idx;
        int seen;

        vecs[0] = '{din: 10'd0,    q: 10'd0,  r: 4'd0,  e00: 1'b0};
        vecs[1] = '{din: 10'd10,   q: 10'd0,  r: 4'd10, e00: 1'b0};
        vecs[2] = '{din: 10'd11,   q: 10'd1,  r: 4'd0,  e00: 1'b0};
        vecs[3] = '{din: 10'd1022, q: 10'd92, r: 4'd10, e00: 1'b1};
        vecs[4] = '{din: 10'd1023, q: 10'd93, r: 4'd0,  e00: 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        i1        = '0;
        tick();
        tick();

        // reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_o1",        32'(o1),        32'd0);
        chk("rst_o2",        32'(o2),        32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;
        tick();

        // single transfers; the 1400 DUT sees the same stimulus
        for (int v = 0; v < 5; v++) begin
            in_valid = 1'b1;
            i1       = vecs[v].din;
            tick();
            in_valid = 1'b0;
            tick();
            tick();
            chk($sformatf("lat3_valid[%0d]", vecs[v].din), 32'(out_valid), 32'd0);
            tick();
            chk($sformatf("lat4_valid[%0d]", vecs[v].din), 32'(out_valid), 32'd1);
            chk($sformatf("q[%0d]",   vecs[v].din), 32'(o1),    32'(vecs[v].q));
            chk($sformatf("r[%0d]",   vecs[v].din), 32'(o2),    32'(vecs[v].r));
            chk($sformatf("err[%0d]", vecs[v].din), 32'(err),   32'd0);
            chk($sformatf("q89[%0d]", vecs[v].din), 32'(q89),   32'(vecs[v].q));
            chk($sformatf("r89[%0d]", vecs[v].din), 32'(r89),   32'(vecs[v].r));
            chk($sformatf("err89[%0d]", vecs[v].din), 32'(err89), 32'd0);
            chk($sformatf("err00[%0d]", vecs[v].din), 32'(err00), 32'(vecs[v].e00));
        end

        // sticky err only clears on reset
        tick();
        chk("err00_still_set", 32'(err00), 32'd1);
        rst = 1'b1;
        #1;
        chk("err00_cleared", 32'(err00), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // exhaustive back-to-back stream
        sb_en  = 1'b1;
        rx_cnt = 0;
        for (int c = 0; c < 1024; c++) begin
            in_valid = 1'b1;
            i1       = 10'(c);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        #1;
        chk("stream_rate_cnt", 32'(rx_cnt), 32'd1024);
        repeat (4) tick();
        chk("stream_final_cnt", 32'(rx_cnt), 32'd1024);
        chk("stream_sb_empty",  32'(sb_q.size()), 32'd0);
        chk("stream_err",       32'(err), 32'd0);

        // backpressure: output held for 6 cycles while a source item waits
        rx_cnt     = 0;
        stall_cnt  = 0;
        prev_stall = 1'b0;
        idx        = 0;
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 4 && c < 10);
            if (idx < 5) begin
                in_valid = 1'b1;
                i1       = 10'(bp_vals[idx]);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready)
                idx++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_stall_cycles", 32'(stall_cnt), 32'd6);
        chk("bp_rx_cnt",       32'(rx_cnt),    32'd5);
        chk("bp_sb_empty",     32'(sb_q.size()), 32'd0);
        sb_en = 1'b0;

        // reset with work in every stage
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            i1       = 10'(50 + 10 * k);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        tick();
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid)
                seen++;
        end
        chk("post_rst_no_stale", 32'(seen), 32'd0);
        in_valid = 1'b1;
        i1       = 10'd777;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_q",     32'(o1),        32'd70);
        chk("post_rst_r",     32'(o2),        32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
